motor_home_sequencer: RTL and testbench

Sequences a stepper-motor homing cycle from debounced sensor states. It runs a fast seek toward the home sensor, backs off a fixed number of steps, then runs a slow re-seek. It generates step/dir/enable directly and reports done or a latched error code. It sits between the per-channel sensor debounce stage and the motor driver pins. It arbitrates motor ownership during homing and is the only consumer of `sensor_home` / `sensor_limit` for motion control.

---
 rtl/motor_home_if.sv | 29 ++
 rtl/motor_home_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_motor_home_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_home_if.sv
// Bundles the homing request/sensor inputs and the motor/status outputs of the
// home sequencer: master drives requests and sensors, slave is the sequencer.
interface motor_home_if;
  logic       home_start;
  logic       home_abort;
  logic       home_dir_cfg;
  logic       sensor_home;
  logic       sensor_limit;
  logic       motor_step;
  logic       motor_dir;
  logic       motor_en;
  logic       home_busy;
  logic       home_done;
  logic       pos_clear;
  logic       home_error;
  logic [1:0] error_code;

  modport master (
    output home_start, home_abort, home_dir_cfg, sensor_home, sensor_limit,
    input  motor_step, motor_dir, motor_en, home_busy, home_done, pos_clear,
           home_error, error_code
  );

  modport slave (
    input  home_start, home_abort, home_dir_cfg, sensor_home, sensor_limit,
    output motor_step, motor_dir, motor_en, home_busy, home_done, pos_clear,
           home_error, error_code
  );
endinterface

// File: rtl/motor_home_sequencer.sv
// Stepper homing sequencer: fast seek to the home sensor, fixed back-off, slow
// re-seek, with registered step/dir/enable and a latched error cause.
module motor_home_sequencer #(
  parameter logic [31:0] FAST_PERIOD   = 32'd500,
  parameter logic [31:0] SLOW_PERIOD   = 32'd5000,
  parameter logic [31:0] PULSE_WIDTH   = 32'd50,
  parameter logic [31:0] BACKOFF_STEPS = 32'd200,
  parameter logic [31:0] MAX_STEPS     = 32'd100000
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  motor_home_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK_FAST,
    S_BACKOFF,
    S_SEEK_SLOW,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LIMIT   = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_period_cnt, w_period_cnt_nxt;
  logic [31:0] r_step_cnt, w_step_cnt_nxt;
  logic [1:0]  r_err_cause, w_err_cause_nxt;
  logic        r_step, w_step_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_en, w_en_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;
  logic [1:0]  r_code, w_code_nxt;

  logic [31:0] w_period;
  logic [31:0] w_period_nxt;
  logic [31:0] w_step_inc;
  logic        w_period_end;
  logic        w_moving_nxt;

  assign w_period     = (r_state == S_SEEK_SLOW) ? SLOW_PERIOD : FAST_PERIOD;
  assign w_period_end = (r_period_cnt == w_period - 32'd1);
  assign w_step_inc   = r_step_cnt + 32'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_period_cnt_nxt = '0;
    w_step_cnt_nxt   = '0;
    w_err_cause_nxt  = r_err_cause;
    w_dir_nxt        = r_dir;
    w_en_nxt         = r_en;
    w_done_nxt       = 1'b0;
    w_error_nxt      = r_error;
    w_code_nxt       = r_code;

    case (r_state)
      S_IDLE: begin
        if (bus.home_start && !bus.home_abort) begin
          w_error_nxt = 1'b0;
          w_code_nxt  = 2'd0;
          w_en_nxt    = 1'b1;
          if (bus.sensor_home) begin
            w_state_nxt = S_BACKOFF;
            w_dir_nxt   = ~bus.home_dir_cfg;
          end else begin
            w_state_nxt = S_SEEK_FAST;
            w_dir_nxt   = bus.home_dir_cfg;
          end
        end
      end

      S_SEEK_FAST, S_BACKOFF, S_SEEK_SLOW: begin
        if (bus.home_abort) begin
          w_state_nxt     = S_ERROR;
          w_err_cause_nxt = ERR_ABORT;
        end else if (bus.sensor_limit && (r_state != S_BACKOFF)) begin
          // Limit is ignored in BACKOFF: the motor is already driving away from it.
          w_state_nxt     = S_ERROR;
          w_err_cause_nxt = ERR_LIMIT;
        end else if (!w_period_end) begin
          w_period_cnt_nxt = r_period_cnt + 32'd1;
          w_step_cnt_nxt   = r_step_cnt;
        end else begin
          // Period end: a sensor hit takes precedence over the step-count timeout.
          case (r_state)
            S_SEEK_FAST: begin
              if (bus.sensor_home) begin
                w_state_nxt = S_BACKOFF;
                w_dir_nxt   = ~bus.home_dir_cfg;
              end else if (w_step_inc == MAX_STEPS) begin
                w_state_nxt     = S_ERROR;
                w_err_cause_nxt = ERR_TIMEOUT;
              end else begin
                w_step_cnt_nxt = w_step_inc;
              end
            end
            S_BACKOFF: begin
              if (w_step_inc == BACKOFF_STEPS) begin
                if (!bus.sensor_home) begin
                  w_state_nxt = S_SEEK_SLOW;
                  w_dir_nxt   = bus.home_dir_cfg;
                end else begin
                  w_state_nxt     = S_ERROR;
                  w_err_cause_nxt = ERR_TIMEOUT;
                end
              end else begin
                w_step_cnt_nxt = w_step_inc;
              end
            end
            default: begin
              if (bus.sensor_home) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end else if (w_step_inc == MAX_STEPS) begin
                w_state_nxt     = S_ERROR;
                w_err_cause_nxt = ERR_TIMEOUT;
              end else begin
                w_step_cnt_nxt = w_step_inc;
              end
            end
          endcase
        end
      end

      S_DONE: begin
        // Driver stays enabled after success to keep holding torque.
        w_state_nxt = S_IDLE;
      end

      S_ERROR: begin
        w_state_nxt = S_IDLE;
        w_error_nxt = 1'b1;
        w_code_nxt  = r_err_cause;
        w_en_nxt    = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_moving_nxt = (w_state_nxt == S_SEEK_FAST) || (w_state_nxt == S_BACKOFF) ||
                   (w_state_nxt == S_SEEK_SLOW);
    w_period_nxt = (w_state_nxt == S_SEEK_SLOW) ? SLOW_PERIOD : FAST_PERIOD;
    // Pulse occupies the tail of each period so dir always has setup time.
    w_step_nxt   = w_moving_nxt && (w_period_cnt_nxt >= w_period_nxt - PULSE_WIDTH);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_period_cnt <= '0;
      r_step_cnt   <= '0;
      r_err_cause  <= 2'd0;
      r_step       <= 1'b0;
      r_dir        <= 1'b0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_code       <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_err_cause  <= w_err_cause_nxt;
      r_step       <= w_step_nxt;
      r_dir        <= w_dir_nxt;
      r_en         <= w_en_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_code       <= w_code_nxt;
    end
  end

  assign bus.motor_step = r_step;
  assign bus.motor_dir  = r_dir;
  assign bus.motor_en   = r_en;
  assign bus.home_busy  = r_busy;
  assign bus.home_done  = r_done;
  assign bus.pos_clear  = r_done;
  assign bus.home_error = r_error;
  assign bus.error_code = r_code;

endmodule

// File: tb/tb_motor_home_sequencer.sv
// Directed bench for motor_home_sequencer: expectations are queued as each
// scenario is driven and popped as the DUT's observable results appear.
module tb_motor_home_sequencer;
  localparam int   FAST    = 10;
  localparam int   SLOW    = 20;
  localparam int   PW      = 3;
  localparam int   BSTEPS  = 4;
  localparam int   MAXS    = 50;
  localparam logic DIR_CFG = 1'b1;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  motor_home_if bus();

  motor_home_sequencer #(
    .FAST_PERIOD  (32'(FAST)),
    .SLOW_PERIOD  (32'(SLOW)),
    .PULSE_WIDTH  (32'(PW)),
    .BACKOFF_STEPS(32'(BSTEPS)),
    .MAX_STEPS    (32'(MAXS))
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Pulse/event monitor, sampled 1 time unit after each active edge.
  int   n_tow   = 0;
  int   n_away  = 0;
  int   n_done  = 0;
  int   n_badw  = 0;
  int   n_badpc = 0;
  int   m_hi    = 0;
  logic m_prev  = 1'b0;

  always @(posedge sys_clk) begin
    #1;
    if (bus.motor_step && !m_prev) begin
      if (bus.motor_dir == DIR_CFG) n_tow++;
      else n_away++;
    end
    if (bus.motor_step) m_hi++;
    else begin
      if (m_prev && m_hi != PW) n_badw++;
      m_hi = 0;
    end
    if (bus.home_done) n_done++;
    if (bus.pos_clear !== bus.home_done) n_badpc++;
    m_prev = bus.motor_step;
  end

  function automatic void push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endfunction

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === 32'(e.exp)) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic budget_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s wait budget expired", tag);
  endtask

  task automatic wait_tow(input int target, input int budget);
    int k = 0;
    while (n_tow < target && k < budget) begin @(negedge sys_clk); k++; end
    if (n_tow < target) budget_fail("wait_toward_pulse");
  endtask

  task automatic wait_away(input int target, input int budget);
    int k = 0;
    while (n_away < target && k < budget) begin @(negedge sys_clk); k++; end
    if (n_away < target) budget_fail("wait_away_pulse");
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.home_busy && k < budget) begin @(negedge sys_clk); k++; end
    if (bus.home_busy) budget_fail("wait_idle");
  endtask

  task automatic start_pulse();
    bus.home_start = 1'b1;
    @(negedge sys_clk);
    bus.home_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b_tow, b_away, b_done, b_badw, b_tow2;

    bus.home_start   = 1'b0;
    bus.home_abort   = 1'b0;
    bus.home_dir_cfg = DIR_CFG;
    bus.sensor_home  = 1'b0;
    bus.sensor_limit = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset state
    push("reset_outputs", 0);
    chk(32'({bus.motor_step, bus.motor_dir, bus.motor_en, bus.home_busy, bus.home_done,
             bus.pos_clear, bus.home_error, bus.error_code}));
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    push("idle_busy_after_reset", 0);
    chk(32'(bus.home_busy));

    // Normal home: 7 fast, 4 back-off, 3 slow, then done
    push("normal_busy_at_start", 1);
    push("normal_dir_at_start", 1);
    push("normal_en_at_start", 1);
    push("normal_first_rise_delay", FAST - PW);
    push("normal_fast_pulses", 7);
    push("normal_backoff_pulses", BSTEPS);
    push("normal_slow_pulses", 3);
    push("normal_done_pulses", 1);
    push("normal_pulse_width_errs", 0);
    push("normal_home_error", 0);
    push("normal_en_held", 1);
    b_tow = n_tow; b_away = n_away; b_done = n_done; b_badw = n_badw;
    start_pulse();
    chk(32'(bus.home_busy));
    chk(32'(bus.motor_dir));
    chk(32'(bus.motor_en));
    k = 0;
    while (!bus.motor_step && k < 100) begin @(negedge sys_clk); k++; end
    chk(32'(k));
    wait_tow(b_tow + 7, 200);
    bus.sensor_home = 1'b1;
    wait_away(b_away + 1, 200);
    chk(32'(n_tow - b_tow));
    wait_away(b_away + 2, 100);
    bus.sensor_home = 1'b0;
    b_tow2 = n_tow;
    wait_tow(b_tow2 + 3, 400);
    bus.sensor_home = 1'b1;
    wait_idle(400);
    chk(32'(n_away - b_away));
    chk(32'(n_tow - b_tow2));
    chk(32'(n_done - b_done));
    chk(32'(n_badw - b_badw));
    chk(32'(bus.home_error));
    chk(32'(bus.motor_en));

    // Start on sensor: back-off first, sensor still set -> timeout error
    push("onsensor_busy", 1);
    push("onsensor_dir", 0);
    push("onsensor_backoff_pulses", BSTEPS);
    push("onsensor_toward_pulses", 0);
    push("onsensor_home_error", 1);
    push("onsensor_error_code", 1);
    push("onsensor_en", 0);
    b_tow = n_tow; b_away = n_away;
    start_pulse();
    chk(32'(bus.home_busy));
    chk(32'(bus.motor_dir));
    wait_idle(200);
    chk(32'(n_away - b_away));
    chk(32'(n_tow - b_tow));
    chk(32'(bus.home_error));
    chk(32'(bus.error_code));
    chk(32'(bus.motor_en));

    // Limit mid-pulse during fast seek
    bus.sensor_home = 1'b0;
    push("limit_step_next_cycle", 0);
    push("limit_busy_in_error", 1);
    push("limit_error_cleared_by_start", 0);
    push("limit_home_error", 1);
    push("limit_error_code", 2);
    push("limit_en", 0);
    push("limit_busy_after", 0);
    start_pulse();
    k = 0;
    while (!bus.motor_step && k < 100) begin @(negedge sys_clk); k++; end
    bus.sensor_limit = 1'b1;
    @(negedge sys_clk);
    chk(32'(bus.motor_step));
    chk(32'(bus.home_busy));
    chk(32'(bus.home_error));
    @(negedge sys_clk);
    chk(32'(bus.home_error));
    chk(32'(bus.error_code));
    chk(32'(bus.motor_en));
    chk(32'(bus.home_busy));
    bus.sensor_limit = 1'b0;

    // Limit during back-off is ignored
    bus.sensor_home = 1'b1;
    push("bo_limit_error_cleared", 0);
    push("bo_limit_backoff_pulses", BSTEPS);
    push("bo_limit_done_pulses", 1);
    push("bo_limit_home_error", 0);
    push("bo_limit_en", 1);
    b_away = n_away; b_done = n_done;
    start_pulse();
    chk(32'(bus.home_error));
    wait_away(b_away + 1, 100);
    bus.sensor_limit = 1'b1;
    wait_away(b_away + 2, 100);
    bus.sensor_limit = 1'b0;
    bus.sensor_home  = 1'b0;
    b_tow = n_tow;
    wait_tow(b_tow + 1, 200);
    bus.sensor_home = 1'b1;
    wait_idle(300);
    chk(32'(n_away - b_away));
    chk(32'(n_done - b_done));
    chk(32'(bus.home_error));
    chk(32'(bus.motor_en));

    // Abort in IDLE (also with a concurrent start) does nothing
    push("idle_abort_busy", 0);
    push("idle_abort_error", 0);
    push("idle_abort_code", 0);
    bus.home_abort = 1'b1;
    repeat (3) @(negedge sys_clk);
    bus.home_start = 1'b1;
    repeat (2) @(negedge sys_clk);
    bus.home_start = 1'b0;
    repeat (2) @(negedge sys_clk);
    bus.home_abort = 1'b0;
    @(negedge sys_clk);
    chk(32'(bus.home_busy));
    chk(32'(bus.home_error));
    chk(32'(bus.error_code));

    // Abort together with limit: abort wins
    bus.sensor_home = 1'b0;
    push("abort_step_next_cycle", 0);
    push("abort_home_error", 1);
    push("abort_error_code", 3);
    push("abort_busy_after", 0);
    start_pulse();
    repeat (3) @(negedge sys_clk);
    bus.home_abort   = 1'b1;
    bus.sensor_limit = 1'b1;
    @(negedge sys_clk);
    chk(32'(bus.motor_step));
    @(negedge sys_clk);
    chk(32'(bus.home_error));
    chk(32'(bus.error_code));
    chk(32'(bus.home_busy));
    bus.home_abort   = 1'b0;
    bus.sensor_limit = 1'b0;

    // Timeout with starts while busy ignored
    push("timeout_pulses", MAXS);
    push("timeout_busy_in_error", 1);
    push("timeout_error_pending", 0);
    push("timeout_busy_after", 0);
    push("timeout_home_error", 1);
    push("timeout_error_code", 1);
    push("timeout_en", 0);
    push("timeout_no_extra_pulses", MAXS);
    b_tow = n_tow;
    start_pulse();
    repeat (20) @(negedge sys_clk);
    start_pulse();
    repeat (60) @(negedge sys_clk);
    start_pulse();
    wait_tow(b_tow + MAXS, 800);
    chk(32'(n_tow - b_tow));
    k = 0;
    while (bus.motor_step && k < 20) begin @(negedge sys_clk); k++; end
    chk(32'(bus.home_busy));
    chk(32'(bus.home_error));
    @(negedge sys_clk);
    chk(32'(bus.home_busy));
    chk(32'(bus.home_error));
    chk(32'(bus.error_code));
    chk(32'(bus.motor_en));
    repeat (40) @(negedge sys_clk);
    chk(32'(n_tow - b_tow));

    // Asynchronous reset mid slow seek, then a complete run
    bus.sensor_home = 1'b1;
    push("pre_reset_step", 1);
    push("pre_reset_dir", 1);
    push("async_reset_outputs", 0);
    push("post_reset_done_pulses", 1);
    push("post_reset_backoff_pulses", BSTEPS);
    push("post_reset_home_error", 0);
    push("post_reset_en", 1);
    b_away = n_away;
    start_pulse();
    wait_away(b_away + 1, 100);
    bus.sensor_home = 1'b0;
    b_tow = n_tow;
    wait_tow(b_tow + 1, 200);
    chk(32'(bus.motor_step));
    chk(32'(bus.motor_dir));
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk(32'({bus.motor_step, bus.motor_dir, bus.motor_en, bus.home_busy, bus.home_done,
             bus.pos_clear, bus.home_error, bus.error_code}));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    b_tow = n_tow; b_away = n_away; b_done = n_done;
    start_pulse();
    wait_tow(b_tow + 2, 100);
    bus.sensor_home = 1'b1;
    wait_away(b_away + 1, 100);
    bus.sensor_home = 1'b0;
    b_tow2 = n_tow;
    wait_tow(b_tow2 + 1, 200);
    bus.sensor_home = 1'b1;
    wait_idle(300);
    chk(32'(n_done - b_done));
    chk(32'(n_away - b_away));
    chk(32'(bus.home_error));
    chk(32'(bus.motor_en));

    push("pos_clear_matches_done", 0);
    chk(32'(n_badpc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
